// File: rtl/filter_access_arbiter.sv
// Round-robin arbiter granting up to four requesters exclusive access to a shared FIR filter.
// Optional WAIT-state watchdog is compiled in when FILTER_ARB_TIMEOUT_EN is defined.
module filter_access_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*4-1:0]          req_taps,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          filt_enable,
    output logic [3:0]                    filt_num_taps,
    output logic                          filt_data_valid,
    output logic [DATA_WIDTH-1:0]         filt_data_in,
    input  logic                          filt_data_ready,
    input  logic                          filt_busy,
    input  logic                          filt_result_valid,
    input  logic [DATA_WIDTH-1:0]         filt_result_out,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_filtered,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    grant_id,
    output logic                          timeout_err,
    output logic [7:0]                    timeout_count
);

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic [3:0]              taps_q, taps_d;
    logic                    first_wait_q, first_wait_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_filtered_q, rsp_filtered_d;

    logic [3:0]              req_pad_s;
    logic [3:0]              grant_hot_s;
    logic [2:0]              idx_s;
    logic [2:0]              rr_nxt_s;
    logic                    found_s;
    logic [1:0]              pick_s;
    logic [3:0]              pick_taps_s;

`ifdef FILTER_ARB_TIMEOUT_EN
    logic [7:0]              wd_q, wd_d;
    logic                    tout_err_q, tout_err_d;
    logic [7:0]              tout_cnt_q, tout_cnt_d;
`endif

    assign req_pad_s   = 4'(req_valid);
    assign grant_hot_s = 4'b0001 << grant_q;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found_s  = 1'b0;
        pick_s   = 2'd0;
        idx_s    = 3'd0;
        rr_nxt_s = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_q} + 3'(k);
            if (idx_s >= 3'(NUM_REQ)) begin
                idx_s = idx_s - 3'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_pad_s[idx_s[1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[1:0];
            end else begin
                found_s = found_s;
            end
        end
        rr_nxt_s = {1'b0, pick_s} + 3'd1;
        if (rr_nxt_s >= 3'(NUM_REQ)) begin
            rr_nxt_s = 3'd0;
        end else begin
            rr_nxt_s = rr_nxt_s;
        end
    end

    assign pick_taps_s = req_taps[int'(pick_s)*4 +: 4];

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        sample_d       = sample_q;
        taps_d         = taps_q;
        first_wait_d   = first_wait_q;
        rsp_data_d     = rsp_data_q;
        rsp_filtered_d = rsp_filtered_q;
`ifdef FILTER_ARB_TIMEOUT_EN
        wd_d           = wd_q;
        tout_err_d     = 1'b0;
        tout_cnt_d     = tout_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && found_s) begin
                    grant_d  = pick_s;
                    rr_ptr_d = rr_nxt_s[1:0];
                    sample_d = req_data[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
                    taps_d   = (pick_taps_s == 4'd0) ? 4'd1 : pick_taps_s;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (filt_data_ready) begin
                    first_wait_d = 1'b1;
`ifdef FILTER_ARB_TIMEOUT_EN
                    wd_d         = 8'd0;
`endif
                    state_d      = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                first_wait_d = 1'b0;
                // An idle filter right after accept means the sample only primed the delay line.
                if (first_wait_q && !filt_busy) begin
                    rsp_data_d     = '0;
                    rsp_filtered_d = 1'b0;
                    state_d        = ST_RESPOND;
                end else if (filt_result_valid) begin
                    rsp_data_d     = filt_result_out;
                    rsp_filtered_d = 1'b1;
                    state_d        = ST_RESPOND;
                end else begin
`ifdef FILTER_ARB_TIMEOUT_EN
                    if (wd_q >= 8'(TIMEOUT_CYCLES - 1)) begin
                        tout_err_d = 1'b1;
                        tout_cnt_d = (tout_cnt_q == 8'd255) ? tout_cnt_q : tout_cnt_q + 8'd1;
                        state_d    = ST_IDLE;
                    end else begin
                        wd_d    = wd_q + 8'd1;
                        state_d = ST_WAIT;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= 2'd0;
            rr_ptr_q       <= 2'd0;
            sample_q       <= '0;
            taps_q         <= 4'd1;
            first_wait_q   <= 1'b0;
            rsp_data_q     <= '0;
            rsp_filtered_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            sample_q       <= sample_d;
            taps_q         <= taps_d;
            first_wait_q   <= first_wait_d;
            rsp_data_q     <= rsp_data_d;
            rsp_filtered_q <= rsp_filtered_d;
        end
    end

`ifdef FILTER_ARB_TIMEOUT_EN
    // Watchdog counter and saturating event counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q       <= 8'd0;
            tout_err_q <= 1'b0;
            tout_cnt_q <= 8'd0;
        end else begin
            wd_q       <= wd_d;
            tout_err_q <= tout_err_d;
            tout_cnt_q <= tout_cnt_d;
        end
    end

    assign timeout_err   = tout_err_q;
    assign timeout_count = tout_cnt_q;
`else
    assign timeout_err   = 1'b0;
    assign timeout_count = 8'd0;
`endif

    assign filt_enable     = enable;
    assign filt_num_taps   = taps_q;
    assign filt_data_valid = (state_q == ST_ISSUE);
    assign filt_data_in    = (state_q == ST_ISSUE) ? sample_q : '0;
    assign req_ready       = ((state_q == ST_ISSUE) && filt_data_ready) ? grant_hot_s[NUM_REQ-1:0] : '0;
    assign rsp_valid       = (state_q == ST_RESPOND) ? grant_hot_s[NUM_REQ-1:0] : '0;
    assign rsp_data        = rsp_data_q;
    assign rsp_filtered    = rsp_filtered_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_filter_access_arbiter.sv
// Scoreboard bench for filter_access_arbiter: driver pushes expectations, negedge monitor pops and compares.
module tb_filter_access_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N*4-1:0] req_taps;
    logic [N-1:0]   req_ready;
    logic           filt_enable;
    logic [3:0]     filt_num_taps;
    logic           filt_data_valid;
    logic [W-1:0]   filt_data_in;
    logic           filt_data_ready, filt_busy, filt_result_valid;
    logic [W-1:0]   filt_result_out;
    logic [N-1:0]   rsp_valid;
    logic           rsp_filtered;
    logic [W-1:0]   rsp_data;
    logic [1:0]     grant_id;
    logic           timeout_err;
    logic [7:0]     timeout_count;

    filter_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_taps(req_taps), .req_ready(req_ready),
        .filt_enable(filt_enable), .filt_num_taps(filt_num_taps),
        .filt_data_valid(filt_data_valid), .filt_data_in(filt_data_in),
        .filt_data_ready(filt_data_ready), .filt_busy(filt_busy),
        .filt_result_valid(filt_result_valid), .filt_result_out(filt_result_out),
        .rsp_valid(rsp_valid), .rsp_filtered(rsp_filtered), .rsp_data(rsp_data),
        .grant_id(grant_id), .timeout_err(timeout_err), .timeout_count(timeout_count)
    );

    always #5 clock = ~clock;

    typedef struct { int id; logic [3:0] taps; logic [W-1:0] data; } iss_t;
    typedef struct { int id; bit filt; logic [W-1:0] data; bit tmo; } rsp_t;

    iss_t   iss_q[$];
    rsp_t   rsp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     res_cyc = 0;
    int     tcnt = 0;
    int     rr_next = 0;
    logic [W-1:0] last_rsp = '0;
    iss_t   ie;
    rsp_t   re;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Spec-level round robin: first requesting index at or after rr_next, modulo N.
    function automatic int rr_pick(logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(rr_next + k) % N]) return (rr_next + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops scoreboard entries on every accept/response/timeout the DUT presents.
    always @(negedge clock) begin
        if (!reset) begin
            iss_q.delete();
            rsp_q.delete();
            last_rsp = '0;
            tcnt = 0;
        end else begin
            if (req_ready != '0) begin
                if (iss_q.size() == 0) check("spurious_req_ready", req_ready, 0);
                else begin
                    ie = iss_q.pop_front();
                    check("req_ready_onehot", req_ready, 64'(1 << ie.id));
                    check("grant_id", grant_id, ie.id);
                    check("num_taps", filt_num_taps, ie.taps);
                    check("filt_data_in", filt_data_in, ie.data);
                    check("rsp_data_hold", rsp_data, last_rsp);
                    acc_cyc = cyc;
                end
            end
            if (filt_result_valid) res_cyc = cyc;
            if (rsp_valid != '0 || timeout_err) begin
                if (rsp_q.size() == 0) check("spurious_rsp", {rsp_valid, timeout_err}, 0);
                else begin
                    re = rsp_q.pop_front();
                    if (re.tmo) begin
                        tcnt = (tcnt < 255) ? tcnt + 1 : tcnt;
                        check("tmo_pulse_only", {rsp_valid, timeout_err}, 1);
                        check("tmo_latency", cyc, acc_cyc + 9);
                        check("tmo_count", timeout_count, tcnt);
                    end else begin
                        check("rsp_valid_onehot", rsp_valid, 64'(1 << re.id));
                        check("rsp_no_tmo", timeout_err, 0);
                        check("rsp_filtered", rsp_filtered, re.filt);
                        check("rsp_data", rsp_data, re.data);
                        check("rsp_latency", cyc, re.filt ? res_cyc + 1 : acc_cyc + 2);
                        check("tmo_count_idle", timeout_count, tcnt);
                        check("filt_enable", filt_enable, enable);
                        last_rsp = re.data;
                    end
                end
            end
        end
    end

    // mode: 0 priming, 1 filtered result after dly WAIT cycles, 2 watchdog expiry, 3 hang in WAIT
    task automatic run_txn(input logic [N-1:0] mask, input int mode, input int bp, input int dly,
                           input bit fixed, input logic [W-1:0] fdata, input logic [3:0] ftaps);
        int g;
        bit seen;
        logic [3:0] t;
        logic [W-1:0] res;
        @(posedge clock); #2;
        enable = 1'b1; req_valid = mask; filt_data_ready = 1'b0;
        filt_busy = 1'b0; filt_result_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = $urandom;
            req_taps[i*4 +: 4] = 4'($urandom_range(0, 15));
        end
        g = rr_pick(mask);
        rr_next = (g + 1) % N;
        if (fixed) begin
            req_data[g*W +: W] = fdata;
            req_taps[g*4 +: 4] = ftaps;
        end
        t = req_taps[g*4 +: 4];
        iss_q.push_back('{g, (t == 4'd0) ? 4'd1 : t, req_data[g*W +: W]});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (filt_data_valid) seen = 1'b1;
        end
        check("grant_wait", seen, 1);
        if (!seen) return;
        @(posedge clock); #2;
        req_valid = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
        filt_data_ready = (bp == 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clock);
            check("bp_valid_held", filt_data_valid, 1);
            check("bp_no_ready", req_ready, 0);
            @(posedge clock); #2;
            filt_data_ready = (i == bp - 1);
        end
        @(posedge clock); #2;
        filt_data_ready = 1'b0;
        enable = 1'($urandom_range(0, 1));
        if (mode == 0) begin
            filt_busy = 1'b0;
            rsp_q.push_back('{g, 1'b0, '0, 1'b0});
        end else if (mode == 1) begin
            filt_busy = 1'b1;
            res = fixed ? fdata : $urandom;
            rsp_q.push_back('{g, 1'b1, res, 1'b0});
            if (dly == 0) begin filt_result_valid = 1'b1; filt_result_out = res; end
            for (int i = 1; i <= dly; i++) begin
                @(posedge clock); #2;
                if (i == dly) begin filt_result_valid = 1'b1; filt_result_out = res; end
            end
            @(posedge clock); #2;
            filt_result_valid = 1'b0; filt_busy = 1'b0;
        end else if (mode == 2) begin
            filt_busy = 1'b1;
            rsp_q.push_back('{g, 1'b0, '0, 1'b1});
        end else begin
            filt_busy = 1'b1;
            return;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (rsp_valid != '0 || timeout_err) seen = 1'b1;
        end
        check("rsp_wait", seen, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_filt_valid", filt_data_valid, 0);
        check("rst_filt_data", filt_data_in, 0);
        check("rst_rsp_data", {rsp_filtered, rsp_data}, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout", {timeout_err, timeout_count}, 0);
        check("rst_num_taps", filt_num_taps, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; req_valid = '0; req_data = '0; req_taps = '0;
        filt_data_ready = 1'b0; filt_busy = 1'b0; filt_result_valid = 1'b0; filt_result_out = '0;
        repeat (3) @(posedge clock);
        #1 check_reset_outputs();
        #1 reset = 1'b1;

        // enable low blocks grants
        @(posedge clock); #2;
        req_valid = '1; enable = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("enable_block", filt_data_valid, 0);
            check("filt_enable_low", filt_enable, 0);
        end

        run_txn(4'b0100, 1, 0, 3, 1'b1, 32'h10, 4'd1);
        run_txn(4'b0010, 1, 0, 1, 1'b0, '0, '0);
        repeat (5) run_txn(4'b1111, 1, 0, 0, 1'b0, '0, '0);
        run_txn(4'b1111, 0, 0, 0, 1'b1, 32'hABCD, 4'd4);
        run_txn(4'b0001, 1, 4, 2, 1'b0, '0, '0);
        run_txn(4'b1000, 0, 0, 0, 1'b1, 32'h55, 4'd0);

        for (int n = 0; n < 40; n++) begin
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 4), 1'b0, '0, '0);
        end

`ifdef FILTER_ARB_TIMEOUT_EN
        run_txn(4'b0110, 2, 0, 0, 1'b0, '0, '0);
        run_txn(4'b1111, 1, 1, 2, 1'b0, '0, '0);
`endif

        // reset while waiting on the filter
        run_txn(4'b1111, 3, 0, 0, 1'b0, '0, '0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        rr_next = 0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1; filt_busy = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("no_rsp_after_reset", rsp_valid, 0);
        end
        run_txn(4'b1111, 0, 0, 0, 1'b0, '0, '0);
        run_txn(4'b1010, 1, 2, 0, 1'b0, '0, '0);

        repeat (3) @(negedge clock);
        check("iss_drain", iss_q.size(), 0);
        check("rsp_drain", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
